// File: rtl/sram_access_ctrl.sv
// SLC-3 memory-access sequencer for a 1Mx16 async SRAM with an I/O window at IO_ADDR.
// Optional macro ACCESS_COUNT_EN adds the Access_count output (completed-access counter).
module sram_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Write,
  input  logic [15:0] Addr,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] Switches,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] Data_to_CPU,
  output logic [15:0] Data_to_SRAM,
  output logic        Drive_en,
  output logic [19:0] ADDR,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic        R,
  output logic        Busy,
  output logic [15:0] Hex_out
`ifdef ACCESS_COUNT_EN
  ,
  output logic [15:0] Access_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        io_hit_q, io_hit_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic        ce_n_q, ce_n_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        drive_q, drive_d;
  logic        r_q, r_d;
  logic        busy_q, busy_d;
  logic        sram_sel;
`ifdef ACCESS_COUNT_EN
  logic [15:0] count_q, count_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    io_hit_d = io_hit_q;
    rdata_d  = rdata_q;
    hex_d    = hex_q;

    case (state_q)
      S_IDLE: begin
        if (Req) begin
          state_d  = S_SETUP;
          addr_d   = Addr;
          write_d  = Write;
          wdata_d  = Data_from_CPU;
          io_hit_d = (Addr == IO_ADDR);
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = WAIT_LOAD;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          // Read data and hex writes land on the DONE entry edge, together with R.
          if (!write_q) begin
            rdata_d = io_hit_q ? Switches : Data_from_SRAM;
          end else if (io_hit_q) begin
            hex_d = wdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they come straight off flops.
    sram_sel = ((state_d == S_SETUP) || (state_d == S_ACCESS)) && !io_hit_d;
    ce_n_d   = !sram_sel;
    ub_n_d   = !sram_sel;
    lb_n_d   = !sram_sel;
    oe_n_d   = !(sram_sel && !write_d);
    drive_d  = (state_d == S_ACCESS) && !io_hit_d && write_d;
    we_n_d   = !drive_d;
    r_d      = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
  end

`ifdef ACCESS_COUNT_EN
  always_comb begin
    count_d = count_q;
    if (state_d == S_DONE) begin
      count_d = count_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      write_q  <= 1'b0;
      io_hit_q <= 1'b0;
      rdata_q  <= 16'h0000;
      hex_q    <= 16'h0000;
      ce_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      drive_q  <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ACCESS_COUNT_EN
      count_q  <= 16'h0000;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      io_hit_q <= io_hit_d;
      rdata_q  <= rdata_d;
      hex_q    <= hex_d;
      ce_n_q   <= ce_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      drive_q  <= drive_d;
      r_q      <= r_d;
      busy_q   <= busy_d;
`ifdef ACCESS_COUNT_EN
      count_q  <= count_d;
`endif
    end
  end

  assign Data_to_CPU  = rdata_q;
  assign Data_to_SRAM = wdata_q;
  assign Drive_en     = drive_q;
  assign ADDR         = {4'b0000, addr_q};
  assign CE           = ce_n_q;
  assign UB           = ub_n_q;
  assign LB           = lb_n_q;
  assign OE           = oe_n_q;
  assign WE           = we_n_q;
  assign R            = r_q;
  assign Busy         = busy_q;
  assign Hex_out      = hex_q;
`ifdef ACCESS_COUNT_EN
  assign Access_count = count_q;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl: stimulus pushes expected completions, a monitor checks each R pulse.
module tb_sram_access_ctrl;

  localparam int W = 2;

  logic        Clk, Reset, Req, Write;
  logic [15:0] Addr, Data_from_CPU, Switches, Data_from_SRAM;
  logic [15:0] Data_to_CPU, Data_to_SRAM, Hex_out;
  logic        Drive_en, CE, UB, LB, OE, WE, R, Busy;
  logic [19:0] ADDR;
`ifdef ACCESS_COUNT_EN
  logic [15:0] Access_count;
`endif

  sram_access_ctrl #(.WAIT_CYCLES(W), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Write(Write), .Addr(Addr),
    .Data_from_CPU(Data_from_CPU), .Switches(Switches), .Data_from_SRAM(Data_from_SRAM),
    .Data_to_CPU(Data_to_CPU), .Data_to_SRAM(Data_to_SRAM), .Drive_en(Drive_en),
    .ADDR(ADDR), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .R(R), .Busy(Busy),
    .Hex_out(Hex_out)
`ifdef ACCESS_COUNT_EN
    , .Access_count(Access_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] rd;
    logic [15:0] hex;
    logic [15:0] wdata;
    logic [19:0] addr;
    logic [15:0] count;
    int          ce_low;
    int          oe_low;
    int          we_low;
    int          drv;
    int          gap;
  } exp_t;

  exp_t        sb_q[$];
  int          n_pass = 0;
  int          n_tot  = 0;
  logic [15:0] exp_rd = 16'h0, exp_hex = 16'h0, exp_count = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  function automatic void push_exp(input logic wr, input logic [15:0] a, input logic [15:0] d,
                                   input int gap);
    exp_t e;
    logic io;
    io = (a == 16'hFFFF);
    if (!wr) exp_rd = io ? Switches : Data_from_SRAM;
    else if (io) exp_hex = d;
    exp_count = exp_count + 16'd1;
    e.rd     = exp_rd;
    e.hex    = exp_hex;
    e.wdata  = d;
    e.addr   = {4'h0, a};
    e.count  = exp_count;
    e.ce_low = io ? 0 : W + 1;
    e.oe_low = (!io && !wr) ? W + 1 : 0;
    e.we_low = (!io && wr) ? W : 0;
    e.drv    = (!io && wr) ? W : 0;
    e.gap    = gap;
    sb_q.push_back(e);
  endfunction

  // Monitor: accumulate strobe activity per access, compare at the R pulse.
  int cyc = 0, last_r = 0, busy_n = 0, ce_n = 0, ublb_n = 0, oe_n = 0, we_n = 0, drv_n = 0;
  always begin
    exp_t e;
    @(negedge Clk);
    cyc++;
    if (!Reset) begin
      busy_n = 0; ce_n = 0; ublb_n = 0; oe_n = 0; we_n = 0; drv_n = 0;
    end else if (R) begin
      if (sb_q.size() == 0) begin
        check("unexpected_R", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        $display("txn addr=%h rd=%h hex=%h at cycle %0d", e.addr, Data_to_CPU, Hex_out, cyc);
        check("latency",      32'(busy_n), 32'(W + 1));
        check("ce_low",       32'(ce_n),   32'(e.ce_low));
        check("ub_lb_low",    32'(ublb_n), 32'(2 * e.ce_low));
        check("oe_low",       32'(oe_n),   32'(e.oe_low));
        check("we_low",       32'(we_n),   32'(e.we_low));
        check("drive_en",     32'(drv_n),  32'(e.drv));
        check("strobes_at_R", 32'({CE, UB, LB, OE, WE, Drive_en, Busy}), 32'(7'b1111101));
        check("data_to_cpu",  32'(Data_to_CPU),  32'(e.rd));
        check("hex_out",      32'(Hex_out),      32'(e.hex));
        check("addr",         32'(ADDR),         32'(e.addr));
        check("data_to_sram", 32'(Data_to_SRAM), 32'(e.wdata));
`ifdef ACCESS_COUNT_EN
        check("access_count", 32'(Access_count), 32'(e.count));
`endif
        if (e.gap != 0) check("r_spacing", 32'(cyc - last_r), 32'(e.gap));
      end
      last_r = cyc;
      busy_n = 0; ce_n = 0; ublb_n = 0; oe_n = 0; we_n = 0; drv_n = 0;
    end else if (Busy) begin
      busy_n++;
      ce_n   += int'(!CE);
      ublb_n += int'(!UB) + int'(!LB);
      oe_n   += int'(!OE);
      we_n   += int'(!WE);
      drv_n  += int'(Drive_en);
    end
  end

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      #1;
      if (!Busy && sb_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    check("idle_reached", 32'(done), 32'd1);
  endtask

  // Single access; inputs are scrambled after acceptance to prove they were latched.
  task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d);
    @(negedge Clk);
    Req = 1'b1; Write = wr; Addr = a; Data_from_CPU = d;
    push_exp(wr, a, d, 0);
    @(posedge Clk);
    #1;
    Req = 1'b0; Write = ~wr; Addr = ~a; Data_from_CPU = ~d;
    wait_idle();
  endtask

  // Write aborted by reset during ACCESS: no R, no hex update, strobes released.
  task automatic reset_abort(input logic [15:0] a, input logic [15:0] d);
    @(negedge Clk);
    Req = 1'b1; Write = 1'b1; Addr = a; Data_from_CPU = d;
    @(posedge Clk);
    #1;
    Req = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("we_in_access", 32'(WE), (a == 16'hFFFF) ? 32'd1 : 32'd0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("abort_state", 32'({Busy, WE, CE, Drive_en, R}), 32'(5'b01100));
    check("abort_hex",   32'(Hex_out), 32'h0);
    exp_rd = 16'h0; exp_hex = 16'h0; exp_count = 16'h0;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (8) @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b0; Req = 1'b0; Write = 1'b0; Addr = 16'h0; Data_from_CPU = 16'h0;
    Switches = 16'h0; Data_from_SRAM = 16'h0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_strobes", 32'({CE, UB, LB, OE, WE}), 32'(5'b11111));
    check("rst_ctrl",    32'({R, Busy, Drive_en}), 32'd0);
    check("rst_data",    32'({Data_to_CPU, Data_to_SRAM}), 32'd0);
    check("rst_addr",    32'(ADDR), 32'd0);
    check("rst_hex",     32'(Hex_out), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    Data_from_SRAM = 16'h1234;
    issue(1'b0, 16'h0010, 16'h0000);
    issue(1'b1, 16'h0020, 16'hBEEF);
    Switches = 16'h00A5;
    issue(1'b0, 16'hFFFF, 16'h0000);
    issue(1'b1, 16'hFFFF, 16'h4C3F);
    Data_from_SRAM = 16'hA5A5;
    issue(1'b0, 16'hFFFE, 16'h0000);
    check("addr_holds_idle", 32'(ADDR), 32'h0FFFE);

    // Req held high: three back-to-back reads spaced W+3 cycles apart.
    @(negedge Clk);
    Data_from_SRAM = 16'h5555;
    Req = 1'b1; Write = 1'b0; Addr = 16'h0030; Data_from_CPU = 16'h0000;
    push_exp(1'b0, 16'h0030, 16'h0000, 0);
    push_exp(1'b0, 16'h0030, 16'h0000, W + 3);
    push_exp(1'b0, 16'h0030, 16'h0000, W + 3);
    repeat (3 * (W + 3) - 4) @(posedge Clk);
    #1;
    Req = 1'b0;
    wait_idle();
    repeat (6) @(negedge Clk);

    reset_abort(16'h0040, 16'hCAFE);
    reset_abort(16'hFFFF, 16'h1111);
    issue(1'b0, 16'h0001, 16'h0000);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
